// File: rtl/ref_strip_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : ref_strip_feeder
//  Purpose  : Producer side of the reference-pixel stream. It fetches 64-bit
//             words from frame memory in strip order through a prefetch FIFO
//             that hides the memory read latency, and presents them to a
//             consumer that never stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module ref_strip_feeder #(
  parameter int STRIPS   = 482,
  parameter int ROWS     = 23,
  parameter int ROW_STEP = 16,
  parameter int BANDS    = 68,
  parameter int MEM_LAT  = 2,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [63:0]       i_mem_rdata,
  input  logic              i_read_en,
  output logic [63:0]       o_ref_in,
  output logic              o_primed,
  output logic              o_underflow,
  output logic              o_busy,
  output logic              o_done
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_SW = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam int c_BW = (BANDS > 1) ? $clog2(BANDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_RW-1:0]   r_r;
  logic [c_SW-1:0]   r_s;
  logic [c_BW-1:0]   r_band;
  logic [ADDR_W-1:0] r_row_base;
  logic [MEM_LAT-1:0] r_tag;
  logic [MEM_LAT:0]  w_tag_nxt;
  logic [c_CW-1:0]   r_out;
  logic [c_CW-1:0]   r_cnt;
  logic [c_AW-1:0]   r_wp;
  logic [c_AW-1:0]   r_rp;
  logic [63:0]       r_mem [DEPTH];
  logic              r_primed;
  logic              r_underflow;

  logic              w_start_acc;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_last_r;
  logic              w_last_s;
  logic              w_last_b;
  logic              w_last_issue;
  logic              w_drained;
  logic [c_CW:0]     w_inflight;
  logic [31:0]       w_addr_full;

  // Issue/return/pop qualifiers and the word address of the current issue
  always_comb begin
    w_empty      = (r_cnt == '0);
    w_inflight   = {1'b0, r_cnt} + {1'b0, r_out};
    w_start_acc  = i_start && (r_state == S_IDLE);
    w_issue      = (r_state == S_FETCH) && (w_inflight < (c_CW+1)'(DEPTH));
    w_tag_nxt    = {r_tag, w_issue};
    w_push       = r_tag[MEM_LAT-1];
    w_pop        = i_read_en && !w_empty && (r_state != S_IDLE);
    w_last_r     = (r_r == c_RW'(ROWS - 1));
    w_last_s     = (r_s == c_SW'(STRIPS - 1));
    w_last_b     = (r_band == c_BW'(BANDS - 1));
    w_last_issue = w_issue && w_last_r && w_last_s && w_last_b;
    w_drained    = w_empty && (r_out == '0);
    w_addr_full  = (32'(r_row_base) + 32'(r_r)) * 32'(STRIPS) + 32'(r_s);
  end

  // Next-state logic and the combinational outputs
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
      S_FETCH: if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) begin
                 w_state_nxt = S_IDLE;
                 o_done      = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
    o_busy      = (r_state != S_IDLE);
    o_mem_rd    = w_issue;
    o_mem_addr  = w_issue ? w_addr_full[ADDR_W-1:0] : '0;
    o_ref_in    = w_empty ? 64'd0 : r_mem[r_rp];
    o_primed    = r_primed;
    o_underflow = r_underflow;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Row / strip / band counters, advanced once per issued read
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_start_acc) begin
      r_r        <= '0;
      r_s        <= '0;
      r_band     <= '0;
      r_row_base <= '0;
    end else if (w_issue) begin
      if (!w_last_r) begin
        r_r <= r_r + 1'b1;
      end else begin
        r_r <= '0;
        if (!w_last_s) begin
          r_s <= r_s + 1'b1;
        end else begin
          r_s        <= '0;
          r_band     <= r_band + 1'b1;
          r_row_base <= r_row_base + ADDR_W'(ROW_STEP);
        end
      end
    end
  end

  // Return-tag pipeline and outstanding-read count; reset drops in-flight tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0;
      r_out <= '0;
    end else begin
      r_tag <= w_tag_nxt[MEM_LAT-1:0];
      case ({w_issue, w_push})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_mem_rdata;
  end

  // primed: FIFO full once, or drain began with data; cleared back in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_primed <= 1'b0;
    else if (r_state == S_IDLE)      r_primed <= 1'b0;
    else if ((r_cnt == c_CW'(DEPTH)) || ((r_state == S_DRAIN) && !w_empty))
                                     r_primed <= 1'b1;
  end

  // underflow: sticky until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_underflow <= 1'b0;
    else if (w_start_acc) r_underflow <= 1'b0;
    else if ((r_state != S_IDLE) && i_read_en && w_empty)
                          r_underflow <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ref_strip_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ref_strip_feeder
//  Purpose  : Directed self-checking bench for ref_strip_feeder with a tiny
//             frame geometry (3 strips, 4 rows, row step 2, 2 bands).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ref_strip_feeder;

  localparam int c_STRIPS   = 3;
  localparam int c_ROWS     = 4;
  localparam int c_ROW_STEP = 2;
  localparam int c_BANDS    = 2;
  localparam int c_MEM_LAT  = 2;
  localparam int c_DEPTH    = 8;
  localparam int c_ADDR_W   = 20;
  localparam int c_WORDS    = c_STRIPS * c_ROWS * c_BANDS;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                mem_rd;
  logic [c_ADDR_W-1:0] mem_addr;
  logic [63:0]         mem_rdata;
  logic                read_en;
  logic [63:0]         ref_in;
  logic                primed;
  logic                underflow;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [c_ADDR_W-1:0] exp_q [$];
  logic [c_ADDR_W-1:0] iss_q [$];
  logic [63:0]         pop_q [$];
  logic [63:0]         p0, p1;

  ref_strip_feeder #(
    .STRIPS(c_STRIPS), .ROWS(c_ROWS), .ROW_STEP(c_ROW_STEP), .BANDS(c_BANDS),
    .MEM_LAT(c_MEM_LAT), .DEPTH(c_DEPTH), .ADDR_W(c_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .o_mem_rd(mem_rd),
    .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .i_read_en(read_en),
    .o_ref_in(ref_in), .o_primed(primed), .o_underflow(underflow),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mdata(input logic [c_ADDR_W-1:0] a);
    return {12'hC0F, a, 12'h5A3, ~a};
  endfunction

  // Frame memory: data of the address presented appears two cycles later
  always @(posedge clk) begin
    p0 <= mdata(mem_addr);
    p1 <= p0;
  end
  assign mem_rdata = p1;

  // Log issued addresses, consumed words and done pulses
  always @(negedge clk) begin
    if (mem_rd)           iss_q.push_back(mem_addr);
    if (read_en && busy)  pop_q.push_back(ref_in);
    if (done)             done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_rd"},    64'(mem_rd),    64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_ref_in"},    ref_in,         64'd0);
    chk({tag, "_primed"},    64'(primed),    64'd0);
    chk({tag, "_underflow"}, 64'(underflow), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  task automatic wait_primed();
    for (int i = 0; i < 100; i++) begin
      if (primed) break;
      @(negedge clk);
    end
    chk("primed_reached", 64'(primed), 64'd1);
  endtask

  task automatic run_pops(input bool_start_pulse);
    @(posedge clk); #1;
    read_en = 1'b1;
    for (int i = 0; i < c_WORDS; i++) begin
      start = bool_start_pulse && (i == 5);
      @(posedge clk); #1;
    end
    read_en = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_issue_count"}, 64'(iss_q.size()), 64'(c_WORDS));
    chk({tag, "_pop_count"},   64'(pop_q.size()), 64'(c_WORDS));
    for (int i = 0; i < c_WORDS; i++) begin
      if (i < iss_q.size())
        chk($sformatf("%s_addr%0d", tag, i), 64'(iss_q[i]), 64'(exp_q[i]));
      if (i < pop_q.size())
        chk($sformatf("%s_data%0d", tag, i), pop_q[i], mdata(exp_q[i]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; read_en = 1'b0;
    // Hand-ordered reference: band, then strip, then row
    for (int b = 0; b < c_BANDS; b++)
      for (int s = 0; s < c_STRIPS; s++)
        for (int r = 0; r < c_ROWS; r++)
          exp_q.push_back(c_ADDR_W'((b * c_ROW_STEP + r) * c_STRIPS + s));

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: early read_en -> underflow; hold off -> fill stops at DEPTH
    iss_q.delete(); pop_q.delete(); done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0; read_en = 1'b1;
    @(posedge clk); #1 read_en = 1'b0;
    @(negedge clk);
    pop_q.delete();
    chk("underflow_set", 64'(underflow), 64'd1);
    chk("busy_fetch", 64'(busy), 64'd1);
    wait_primed();
    chk("mem_rd_when_primed", 64'(mem_rd), 64'd0);
    repeat (10) @(negedge clk);
    chk("held_issue_count", 64'(iss_q.size()), 64'(c_DEPTH));
    chk("held_mem_rd", 64'(mem_rd), 64'd0);
    chk("underflow_sticky", 64'(underflow), 64'd1);
    run_pops(1'b1);
    wait_done();
    check_frame("f1");
    chk("underflow_kept", 64'(underflow), 64'd1);

    // Start clears underflow; then reset mid-frame with reads in flight
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("underflow_cleared", 64'(underflow), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk_idle_outputs("midreset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_ref_in", ref_in, 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_mem_rd", 64'(mem_rd), 64'd0);

    // Frame 2: clean run from address 0
    iss_q.delete(); pop_q.delete(); done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_primed();
    run_pops(1'b0);
    wait_done();
    check_frame("f2");
    chk("f2_underflow", 64'(underflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
